// File: rtl/dmem_cache_responder_if.sv
// Data-memory bus bundle for dmem_cache_responder.
// Groups two sides of the bus:
//   - requester side: Addr_i, WriteD_i, Mwrite_i, Mread_i and funct3_i in;
//     ReadD_o and Mready_o out.
//   - backing-memory side: MemReq_o, MemWe_o, MemAddr_o, MemWData_o and
//     MemBe_o out; MemRData_i and MemAck_i in.
// Signal suffixes are named from the responder's point of view.
// The slave modport is the responder (the cache).
// The master modport is whoever drives the requests and answers the
// backing-memory port.
interface dmem_cache_responder_if;
  logic [31:0] Addr_i;
  logic [31:0] WriteD_i;
  logic        Mwrite_i;
  logic        Mread_i;
  logic [2:0]  funct3_i;
  logic [31:0] ReadD_o;
  logic        Mready_o;
  logic        MemReq_o;
  logic        MemWe_o;
  logic [31:0] MemAddr_o;
  logic [31:0] MemWData_o;
  logic [3:0]  MemBe_o;
  logic [31:0] MemRData_i;
  logic        MemAck_i;

  modport slave (
    input  Addr_i, WriteD_i, Mwrite_i, Mread_i, funct3_i, MemRData_i, MemAck_i,
    output ReadD_o, Mready_o, MemReq_o, MemWe_o, MemAddr_o, MemWData_o, MemBe_o
  );

  modport master (
    output Addr_i, WriteD_i, Mwrite_i, Mread_i, funct3_i, MemRData_i, MemAck_i,
    input  ReadD_o, Mready_o, MemReq_o, MemWe_o, MemAddr_o, MemWData_o, MemBe_o
  );
endinterface

// File: rtl/dmem_cache_responder.sv
// dmem_cache_responder: data-memory responder for the pipeline's memory stage.
// It fronts a direct-mapped cache with these properties:
//   - one-word lines;
//   - write-through;
//   - no write allocate.
// Load hits complete combinationally in the request cycle.
// Load misses and all stores go to the backing memory over a req/ack port.
// The requester is stalled by holding Mready_o low.
// Ports:
//   clk_i   : clock; all state updates on the rising edge.
//   reset_i : synchronous, active-high reset.
//   bus     : dmem_cache_responder_if.slave. Carries the requester request
//             and response signals and the backing-memory req/ack port.
// Parameter:
//   SETS    : number of cache lines (power of two, >= 2).
module dmem_cache_responder #(
  parameter int SETS = 16
) (
  input logic                   clk_i,
  input logic                   reset_i,
  dmem_cache_responder_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

  state_t            state;
  logic [31:0]       data_arr [SETS];
  logic [TAG_W-1:0]  tag_arr  [SETS];
  logic [SETS-1:0]   valid;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  pend_idx;
  logic [TAG_W-1:0]  pend_tag;
  logic [31:0]       line;
  logic              hit;
  logic [31:0]       load_data;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic [31:0]       merged;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  assign idx      = bus.Addr_i[IDX_W+1:2];
  assign tag      = bus.Addr_i[31:IDX_W+2];
  assign pend_idx = mem_addr[IDX_W+1:2];
  assign pend_tag = mem_addr[31:IDX_W+2];
  assign line     = data_arr[idx];
  assign hit      = valid[idx] && (tag_arr[idx] == tag);

  // Load extraction: halfwords ignore Addr_i[0] and words ignore Addr_i[1:0].
  // Unlisted funct3 codes fall back to a plain word read.
  always_comb begin
    byte_sel = line[{bus.Addr_i[1:0], 3'b000} +: 8];
    half_sel = bus.Addr_i[1] ? line[31:16] : line[15:0];
    case (bus.funct3_i)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'b0, byte_sel};
      3'b101:  load_data = {16'b0, half_sel};
      default: load_data = line;
    endcase
  end

  // Store lane placement: data is shifted into its byte lanes with the other
  // lanes zero, so the backing memory only needs the byte enables.
  always_comb begin
    case (bus.funct3_i[1:0])
      2'b00: begin
        st_be    = 4'b0001 << bus.Addr_i[1:0];
        st_wdata = {24'b0, bus.WriteD_i[7:0]} << {bus.Addr_i[1:0], 3'b000};
      end
      2'b01: begin
        st_be    = bus.Addr_i[1] ? 4'b1100 : 4'b0011;
        st_wdata = {16'b0, bus.WriteD_i[15:0]} << {bus.Addr_i[1], 4'b0000};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = bus.WriteD_i;
      end
    endcase
  end

  // Byte merge of the pending store into the addressed line (used on a write hit).
  always_comb begin
    merged = data_arr[pend_idx];
    for (int b = 0; b < 4; b++) begin
      if (mem_be[b]) merged[8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  // Requester response: only an IDLE load hit or RESP releases a pending request.
  // A store always stalls, even when Mread_i is also asserted.
  always_comb begin
    bus.Mready_o = 1'b0;
    bus.ReadD_o  = 32'b0;
    case (state)
      IDLE: begin
        if (bus.Mwrite_i) begin
          bus.Mready_o = 1'b0;
        end else if (bus.Mread_i) begin
          bus.Mready_o = hit;
          if (hit) bus.ReadD_o = load_data;
        end else begin
          bus.Mready_o = 1'b1;
        end
      end
      RESP:    bus.Mready_o = 1'b1;
      default: bus.Mready_o = 1'b0;
    endcase
  end

  // Controller FSM and cache state update.
  // The backing-port outputs are registered and held until the ack cycle.
  // Reset clears only the valid bits; the data and tag arrays keep their contents.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= IDLE;
      valid     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'b0;
      mem_wdata <= 32'b0;
      mem_be    <= 4'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Mwrite_i) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {bus.Addr_i[31:2], 2'b00};
            mem_wdata <= st_wdata;
            mem_be    <= st_be;
            state     <= WRITE;
          end else if (bus.Mread_i && !hit) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {bus.Addr_i[31:2], 2'b00};
            mem_wdata <= 32'b0;
            mem_be    <= 4'b0;
            state     <= FILL;
          end
        end
        FILL: begin
          if (bus.MemAck_i) begin
            data_arr[pend_idx] <= bus.MemRData_i;
            tag_arr[pend_idx]  <= pend_tag;
            valid[pend_idx]    <= 1'b1;
            mem_req            <= 1'b0;
            state              <= IDLE;
          end
        end
        WRITE: begin
          if (bus.MemAck_i) begin
            if (valid[pend_idx] && (tag_arr[pend_idx] == pend_tag)) begin
              data_arr[pend_idx] <= merged;
            end
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.MemReq_o   = mem_req;
  assign bus.MemWe_o    = mem_we;
  assign bus.MemAddr_o  = mem_addr;
  assign bus.MemWData_o = mem_wdata;
  assign bus.MemBe_o    = mem_be;
endmodule
